// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: opcodes, halt causes and FSM states shared by cpu_run_ctrl and rf_dump_seq
package cpu_dbg_pkg;
  localparam int DBG_XLEN = 32;
  localparam logic [2:0] OP_HALT   = 3'd0;
  localparam logic [2:0] OP_RUN    = 3'd1;
  localparam logic [2:0] OP_STEP   = 3'd2;
  localparam logic [2:0] OP_RUN_N  = 3'd3;
  localparam logic [2:0] OP_DUMP   = 3'd4;
  localparam logic [2:0] OP_SET_BP = 3'd5;
  localparam logic [2:0] OP_CLR_BP = 3'd6;
  localparam logic [1:0] CAUSE_RESET = 2'd0;
  localparam logic [1:0] CAUSE_CMD   = 2'd1;
  localparam logic [1:0] CAUSE_COUNT = 2'd2;
  localparam logic [1:0] CAUSE_BP    = 2'd3;
  localparam logic [4:0] DUMP_LAST = 5'd31;
  typedef enum logic [1:0] {ST_HALTED, ST_RUN, ST_RUN_N, ST_DUMP} state_e;
endpackage

// File: rtl/rf_dump_seq.sv
// rf_dump_seq: walks register indices 0..31 as valid/ready beats after a start pulse, pulses done on the last beat
module rf_dump_seq
  import cpu_dbg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [4:0] idx_o,
  output logic       done_o
);
  logic active_q, active_d;
  logic [4:0] idx_q, idx_d;
  logic fire;
  assign fire = active_q && ready_i;
  assign valid_o = active_q;
  assign idx_o = idx_q;
  assign done_o = fire && idx_q == DUMP_LAST;
  always_comb begin
    active_d = start_i ? 1'b1 : done_o ? 1'b0 : active_q;
    idx_d = start_i ? 5'd0 : fire ? idx_q + 5'd1 : idx_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      idx_q <= 5'd0;
    end else begin
      active_q <= active_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: halt/run/step/run-N/dump sequencer for the core; PC breakpoint built only with CPU_RUN_CTRL_BREAKPOINT_EN
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int XLEN  = DBG_XLEN,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [XLEN-1:0] cmd_arg,
  input  logic [XLEN-1:0] pc,
  output logic            cpu_en,
  output logic [4:0]      rf_addr,
  input  logic [XLEN-1:0] rf_data,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [4:0]      dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            halted,
  output logic [1:0]      halt_cause
);
  state_e state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, arg_cnt;
  logic acc, running, bp_hit, dump_start, dump_done;
  assign arg_cnt = cmd_arg[CNT_W-1:0];
  assign cmd_ready = !rst && state_q != ST_DUMP;
  assign acc = cmd_valid && cmd_ready;
  assign running = state_q == ST_RUN || state_q == ST_RUN_N;
  assign cpu_en = running && !bp_hit;
  assign halted = !running;
  assign halt_cause = cause_q;
  assign rf_addr = state_q == ST_DUMP ? dump_idx : 5'd0;
  assign dump_data = rf_data;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  logic [XLEN-1:0] bp_pc_q, bp_pc_d;
  logic armed_q, armed_d, skip_q, skip_d, resume;
  // skip lets a resume from the breakpoint PC commit that instruction once
  assign resume = acc && state_q == ST_HALTED &&
                  (cmd_op == OP_RUN || cmd_op == OP_STEP || cmd_op == OP_RUN_N);
  assign bp_hit = armed_q && pc == bp_pc_q && !skip_q;
  always_comb begin
    bp_pc_d = acc && cmd_op == OP_SET_BP ? cmd_arg : bp_pc_q;
    armed_d = acc && cmd_op == OP_SET_BP ? 1'b1 : acc && cmd_op == OP_CLR_BP ? 1'b0 : armed_q;
    skip_d = resume ? 1'b1 : cpu_en ? 1'b0 : skip_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_pc_q <= '0;
      armed_q <= 1'b0;
      skip_q <= 1'b0;
    end else begin
      bp_pc_q <= bp_pc_d;
      armed_q <= armed_d;
      skip_q <= skip_d;
    end
  end
`else
  logic unused_bp;
  assign unused_bp = ^{pc, cmd_arg[XLEN-1:CNT_W]};
  assign bp_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d = cnt_q;
    dump_start = 1'b0;
    case (state_q)
      ST_HALTED: begin
        if (acc && cmd_op == OP_RUN) state_d = ST_RUN;
        if (acc && cmd_op == OP_STEP) begin
          state_d = ST_RUN_N;
          cnt_d = CNT_W'(1);
        end
        if (acc && cmd_op == OP_RUN_N) begin
          state_d = arg_cnt == '0 ? ST_HALTED : ST_RUN_N;
          cause_d = arg_cnt == '0 ? CAUSE_COUNT : cause_q;
          cnt_d = arg_cnt;
        end
        if (acc && cmd_op == OP_DUMP) begin
          state_d = ST_DUMP;
          dump_start = 1'b1;
        end
      end
      ST_DUMP: state_d = dump_done ? ST_HALTED : ST_DUMP;
      default: begin
        if (cpu_en && state_q == ST_RUN_N) cnt_d = cnt_q - 1'b1;
        // priority BP > COUNT > CMD
        if (bp_hit) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BP;
        end else if (state_q == ST_RUN_N && cnt_q == CNT_W'(1)) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_COUNT;
        end else if (acc && cmd_op == OP_HALT) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_CMD;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HALTED;
      cause_q <= CAUSE_RESET;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q <= cnt_d;
    end
  end
  rf_dump_seq u_dump (
    .clk     (clk),
    .rst     (rst),
    .start_i (dump_start),
    .ready_i (dump_ready),
    .valid_o (dump_valid),
    .idx_o   (dump_idx),
    .done_o  (dump_done)
  );
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: vector table, directed corner sequences and random commands against a mode-level model
module tb_cpu_run_ctrl;
  import cpu_dbg_pkg::*;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_ready, cpu_en, dump_valid, dump_ready = 1'b0, halted;
  logic [2:0] cmd_op = 3'd0;
  logic [31:0] cmd_arg = 32'd0, pc_m, rf_data, dump_data;
  logic [4:0] rf_addr, dump_idx;
  logic [1:0] halt_cause, cause_before;
  logic [31:0] rf [32];
  int total = 0, bad = 0, en_total = 0, e0, beat, n, r;
  typedef struct {
    logic v; logic [2:0] op; logic [31:0] arg;
    logic en; logic hlt; logic [1:0] cause;
  } vec_t;
  vec_t tbl [15];
  logic [2:0] opmap [10];
  int m_rem;
  logic [1:0] m_cause;
  logic [31:0] m_bp;
  bit m_armed, m_fresh, bphit;

  cpu_run_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .pc(pc_m), .cpu_en(cpu_en), .rf_addr(rf_addr), .rf_data(rf_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .halted(halted), .halt_cause(halt_cause)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pc_m <= rst ? 32'd0 : cpu_en ? pc_m + 32'd4 : pc_m;
  always @(negedge clk) if (cpu_en === 1'b1) en_total++;
  assign rf_data = rf[rf_addr];

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] arg);
    cmd_op = op;
    cmd_arg = arg;
    cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    dump_ready = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_halted", halted, 1);
    chk("rst_cause", halt_cause, CAUSE_RESET);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_dump_idx", dump_idx, 0);
    cyc();
  endtask

  initial begin
    tbl[0]  = '{1'b0, OP_HALT,   32'd0,         1'b0, 1'b1, 2'd0};
    tbl[1]  = '{1'b1, OP_RUN_N,  32'd0,         1'b0, 1'b1, 2'd0};
    tbl[2]  = '{1'b1, OP_HALT,   32'd0,         1'b0, 1'b1, 2'd2};
    tbl[3]  = '{1'b1, 3'd7,      32'd0,         1'b0, 1'b1, 2'd2};
    tbl[4]  = '{1'b1, OP_RUN,    32'd0,         1'b0, 1'b1, 2'd2};
    tbl[5]  = '{1'b1, 3'd7,      32'd0,         1'b1, 1'b0, 2'd2};
    tbl[6]  = '{1'b1, OP_RUN,    32'd0,         1'b1, 1'b0, 2'd2};
    tbl[7]  = '{1'b1, OP_HALT,   32'd0,         1'b1, 1'b0, 2'd2};
    tbl[8]  = '{1'b1, OP_STEP,   32'd0,         1'b0, 1'b1, 2'd1};
    tbl[9]  = '{1'b0, OP_HALT,   32'd0,         1'b1, 1'b0, 2'd1};
    tbl[10] = '{1'b1, OP_RUN_N,  32'hFFFF0002,  1'b0, 1'b1, 2'd2};
    tbl[11] = '{1'b0, OP_HALT,   32'd0,         1'b1, 1'b0, 2'd2};
    tbl[12] = '{1'b1, OP_CLR_BP, 32'd0,         1'b1, 1'b0, 2'd2};
    tbl[13] = '{1'b0, OP_HALT,   32'd0,         1'b0, 1'b1, 2'd2};
    tbl[14] = '{1'b0, OP_HALT,   32'd0,         1'b0, 1'b1, 2'd2};
    opmap = '{OP_HALT, OP_RUN, OP_STEP, OP_RUN_N, OP_RUN_N, OP_SET_BP, OP_CLR_BP, 3'd7, OP_HALT, OP_RUN};
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;

    do_reset();
    for (int i = 0; i < 15; i++) begin
      cmd_valid = tbl[i].v;
      cmd_op = tbl[i].op;
      cmd_arg = tbl[i].arg;
      @(negedge clk);
      chk($sformatf("tbl%0d_en", i), cpu_en, tbl[i].en);
      chk($sformatf("tbl%0d_halted", i), halted, tbl[i].hlt);
      chk($sformatf("tbl%0d_cause", i), halt_cause, tbl[i].cause);
      chk($sformatf("tbl%0d_ready", i), cmd_ready, 1);
      cyc();
    end
    cmd_valid = 1'b0;

    // RUN, five cycles, then HALT: six commits including the HALT cycle
    do_reset();
    e0 = en_total;
    send(OP_RUN, 0);
    repeat (5) cyc();
    send(OP_HALT, 0);
    repeat (3) cyc();
    chk("run_halt_commits", en_total - e0, 6);
    chk("run_halt_pc", pc_m, 24);
    chk("run_halt_halted", halted, 1);
    chk("run_halt_cause", halt_cause, CAUSE_CMD);

    e0 = en_total;
    send(OP_RUN_N, 0);
    repeat (2) cyc();
    chk("runn0_commits", en_total - e0, 0);
    chk("runn0_cause", halt_cause, CAUSE_COUNT);
    chk("runn0_halted", halted, 1);
    send(OP_RUN_N, 3);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("runn3_en%0d", i), cpu_en, i < 3);
      cyc();
    end
    chk("runn3_pc", pc_m, 36);
    chk("runn3_halted", halted, 1);
    chk("runn3_cause", halt_cause, CAUSE_COUNT);

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    do_reset();
    send(OP_SET_BP, 32'h0000000C);
    e0 = en_total;
    send(OP_RUN, 0);
    for (int i = 0; i < 20 && pc_m != 32'hC; i++) cyc();
    chk("bp_pc_reached", pc_m, 32'hC);
    chk("bp_en_drop", cpu_en, 0);
    chk("bp_halted_late", halted, 0);
    cyc();
    chk("bp_halted", halted, 1);
    chk("bp_cause", halt_cause, CAUSE_BP);
    chk("bp_commits", en_total - e0, 3);
    e0 = en_total;
    send(OP_STEP, 0);
    repeat (3) cyc();
    chk("bp_step_commits", en_total - e0, 1);
    chk("bp_step_pc", pc_m, 32'h10);
    chk("bp_step_cause", halt_cause, CAUSE_COUNT);
    do_reset();
    send(OP_SET_BP, 32'h8);
    e0 = en_total;
    send(OP_RUN_N, 3);
    repeat (5) cyc();
    chk("bpcnt_commits", en_total - e0, 2);
    chk("bpcnt_pc", pc_m, 32'h8);
    chk("bpcnt_cause", halt_cause, CAUSE_BP);
`else
    do_reset();
    send(OP_SET_BP, 32'h0000000C);
    e0 = en_total;
    send(OP_RUN_N, 5);
    repeat (7) cyc();
    chk("nobp_commits", en_total - e0, 5);
    chk("nobp_pc", pc_m, 32'h14);
    chk("nobp_cause", halt_cause, CAUSE_COUNT);
`endif

    // DUMP with toggling ready; a RUN offered throughout must be refused
    cause_before = halt_cause;
    send(OP_DUMP, 0);
    chk("dump_first_valid", dump_valid, 1);
    chk("dump_first_idx", dump_idx, 0);
    cmd_valid = 1'b1;
    cmd_op = OP_RUN;
    beat = 0;
    for (int c = 0; c < 200 && beat < 32; c++) begin
      dump_ready = (c % 2) == 1;
      @(negedge clk);
      chk("dump_valid", dump_valid, 1);
      chk("dump_cmd_ready", cmd_ready, 0);
      chk("dump_halted", halted, 1);
      chk("dump_idx", dump_idx, beat);
      chk("dump_data", dump_data, rf[beat]);
      if (dump_ready) beat++;
      if (beat == 32) cmd_valid = 1'b0;
      cyc();
    end
    cmd_valid = 1'b0;
    dump_ready = 1'b0;
    chk("dump_beats", beat, 32);
    chk("dump_end_valid", dump_valid, 0);
    chk("dump_end_halted", halted, 1);
    chk("dump_end_ready", cmd_ready, 1);
    chk("dump_end_cause", halt_cause, cause_before);
    chk("dump_end_en", cpu_en, 0);

    send(OP_DUMP, 0);
    dump_ready = 1'b1;
    for (int i = 0; i < 40 && dump_idx != 5'd10; i++) cyc();
    chk("dumprst_idx10", dump_idx, 10);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("dumprst_valid", dump_valid, 0);
    chk("dumprst_cause", halt_cause, CAUSE_RESET);
    chk("dumprst_halted", halted, 1);
    chk("dumprst_en", cpu_en, 0);
    send(OP_DUMP, 0);
    chk("redump_idx0", dump_idx, 0);
    chk("redump_valid", dump_valid, 1);
    n = 0;
    while (n < 40 && dump_valid) begin
      cyc();
      n++;
    end
    chk("redump_cycles", n, 32);
    dump_ready = 1'b0;

    // random commands against a mode-level model: m_rem = -1 free run, 0 halted, >0 commits left
    do_reset();
    m_rem = 0; m_cause = CAUSE_RESET; m_bp = 0; m_armed = 0; m_fresh = 0;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 9);
      cmd_valid = $urandom_range(0, 3) == 0;
      cmd_op = opmap[r];
      cmd_arg = cmd_op == OP_RUN_N ? (($urandom & 32'hFFFF0000) | $urandom_range(0, 6)) :
                cmd_op == OP_SET_BP ? pc_m + 32'(4 * $urandom_range(0, 6)) : $urandom;
      @(negedge clk);
      bphit = BP_EN && m_armed && pc_m == m_bp && !m_fresh && m_rem != 0;
      chk("rnd_en", cpu_en, m_rem != 0 && !bphit);
      chk("rnd_halted", halted, m_rem == 0);
      chk("rnd_cause", halt_cause, m_cause);
      chk("rnd_ready", cmd_ready, 1);
      if (m_rem != 0) begin
        if (bphit) begin
          m_rem = 0;
          m_cause = CAUSE_BP;
        end else begin
          m_fresh = 0;
          if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_cause = CAUSE_COUNT;
          end
          if (m_rem != 0 && cmd_valid && cmd_op == OP_HALT) begin
            m_rem = 0;
            m_cause = CAUSE_CMD;
          end
        end
      end else if (cmd_valid) begin
        if (cmd_op == OP_RUN) begin m_rem = -1; m_fresh = 1; end
        if (cmd_op == OP_STEP) begin m_rem = 1; m_fresh = 1; end
        if (cmd_op == OP_RUN_N) begin
          m_fresh = 1;
          m_rem = int'(cmd_arg & 32'hFFFF);
          if (m_rem == 0) m_cause = CAUSE_COUNT;
        end
      end
      if (cmd_valid && BP_EN && cmd_op == OP_SET_BP) begin m_armed = 1; m_bp = cmd_arg; end
      if (cmd_valid && BP_EN && cmd_op == OP_CLR_BP) m_armed = 0;
      cyc();
    end
    cmd_valid = 1'b0;

    send(OP_RUN, 0);
    cyc();
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
